// File: rtl/labs_energy_check.sv
// Serial checker for a candidate sequence's aperiodic autocorrelation energy, one lag per cycle.
// Optional peak-sidelobe tracking on o_psl is enabled by defining LABS_PSL_EN.
module labs_energy_check #(
  parameter int unsigned SEQ_WIDTH = 16,
  parameter int unsigned E_WIDTH   = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEQ_WIDTH-1:0] i_seq,
  input  logic [E_WIDTH-1:0]   i_e,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [E_WIDTH-1:0]   o_e,
  output logic                 o_match,
  output logic [SEQ_WIDTH-1:0] o_psl,
  output logic                 o_valid,
  input  logic                 i_ready
);

  // KW holds 0..N; AW also holds 2*popcount without overflow.
  localparam int unsigned KW = $clog2(SEQ_WIDTH + 1);
  localparam int unsigned AW = KW + 1;
  localparam int unsigned SW = 2 * AW;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e               state_q, state_d;
  logic [SEQ_WIDTH-1:0] seq_q;
  logic [E_WIDTH-1:0]   claim_q;
  logic [E_WIDTH-1:0]   acc_q, acc_d;
  logic [E_WIDTH-1:0]   e_q;
  logic                 match_q;
  logic [KW-1:0]        k_q;
  logic                 accept;
  logic                 last_lag;

  logic [SEQ_WIDTH-1:0] diff;
  logic [KW-1:0]        pop;
  logic [AW-1:0]        span;
  logic [AW-1:0]        two_pop;
  logic [AW-1:0]        mag;
  logic [SW-1:0]        sq;

  assign accept   = (state_q == StIdle) && i_valid;
  assign last_lag = (k_q == KW'(SEQ_WIDTH - 1));

  // |C_k| = |(N-k) - 2*mismatches| over the N-k overlapping pairs.
  always_comb begin
    diff = (seq_q ^ (seq_q >> k_q)) & ({SEQ_WIDTH{1'b1}} >> k_q);
    pop  = '0;
    for (int i = 0; i < SEQ_WIDTH; i++) begin
      pop = pop + KW'(diff[i]);
    end
    span    = AW'(SEQ_WIDTH) - AW'(k_q);
    two_pop = {pop, 1'b0};
    mag     = (span >= two_pop) ? (span - two_pop) : (two_pop - span);
    sq      = SW'(mag) * SW'(mag);
    acc_d   = acc_q + E_WIDTH'(sq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_valid) state_d = StCalc;
      StCalc:  if (last_lag) state_d = StDone;
      StDone:  if (i_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    unique case (state_q)
      StIdle:  o_ready = 1'b1;
      StDone:  o_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q   <= '0;
      claim_q <= '0;
      acc_q   <= '0;
      k_q     <= KW'(1);
      e_q     <= '0;
      match_q <= 1'b0;
    end else if (accept) begin
      seq_q   <= i_seq;
      claim_q <= i_e;
      acc_q   <= '0;
      k_q     <= KW'(1);
    end else if (state_q == StCalc) begin
      acc_q <= acc_d;
      k_q   <= k_q + KW'(1);
      if (last_lag) begin
        e_q     <= acc_d;
        match_q <= (acc_d == claim_q);
      end
    end
  end

  assign o_e     = e_q;
  assign o_match = match_q;

`ifdef LABS_PSL_EN
  logic [AW-1:0] psl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psl_q <= '0;
    end else if (accept) begin
      psl_q <= '0;
    end else if ((state_q == StCalc) && (mag > psl_q)) begin
      psl_q <= mag;
    end
  end

  assign o_psl = SEQ_WIDTH'(psl_q);
`else
  assign o_psl = '0;
`endif

endmodule

// File: tb/tb_labs_energy_check.sv
// Self-checking bench for labs_energy_check: directed cases, backpressure, mid-run reset and
// random sequences against a +/-1 autocorrelation model. Honours LABS_PSL_EN for o_psl.
module tb_labs_energy_check;

  localparam int N  = 16;
  localparam int N2 = 13;
  localparam int EW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  i_seq = '0;
  logic [EW-1:0] i_e = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [EW-1:0] o_e;
  logic          o_match;
  logic [N-1:0]  o_psl;
  logic          o_valid;
  logic          i_ready = 1'b1;

  logic [N2-1:0] b_seq = '0;
  logic [EW-1:0] b_e = '0;
  logic          b_valid = 1'b0;
  logic          b_oready;
  logic [EW-1:0] b_oe;
  logic          b_match;
  logic [N2-1:0] b_psl;
  logic          b_ovalid;
  logic          b_iready = 1'b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  labs_energy_check #(.SEQ_WIDTH(N), .E_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n), .i_seq(i_seq), .i_e(i_e), .i_valid(i_valid),
    .o_ready(o_ready), .o_e(o_e), .o_match(o_match), .o_psl(o_psl),
    .o_valid(o_valid), .i_ready(i_ready)
  );

  labs_energy_check #(.SEQ_WIDTH(N2), .E_WIDTH(EW)) dut13 (
    .clk(clk), .rst_n(rst_n), .i_seq(b_seq), .i_e(b_e), .i_valid(b_valid),
    .o_ready(b_oready), .o_e(b_oe), .o_match(b_match), .o_psl(b_psl),
    .o_valid(b_ovalid), .i_ready(b_iready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Energy = sum over k of (sum_i s_i*s_(i+k))^2 with s = +/-1, wrapped to EW bits.
  function automatic void model(input logic [63:0] seq, input int n,
                                output logic [63:0] e, output logic [63:0] psl);
    longint acc = 0;
    int     pk  = 0;
    for (int k = 1; k < n; k++) begin
      int c = 0;
      int a;
      for (int i = 0; i + k < n; i++) c += (seq[i] == seq[i+k]) ? 1 : -1;
      acc += longint'(c * c);
      a = (c < 0) ? -c : c;
      if (a > pk) pk = a;
    end
    e = 64'(acc) & ((64'd1 << EW) - 64'd1);
`ifdef LABS_PSL_EN
    psl = 64'(pk);
`else
    psl = 64'd0;
`endif
  endfunction

  task automatic run_one(input logic [N-1:0] seq, input logic [EW-1:0] claim, input string tag);
    logic [63:0] ee, pp;
    int          lat;
    bit          seen;
    model(64'(seq), N, ee, pp);
    for (int t = 0; t < 50 && !o_ready; t++) begin
      @(posedge clk); #1;
    end
    check({tag, "_ready"}, 64'(o_ready), 64'd1);
    i_seq   = seq;
    i_e     = claim;
    i_valid = 1'b1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_seq   = N'($urandom);
    i_e     = EW'($urandom);
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      seen = o_valid;
    end
    check({tag, "_latency"}, 64'(lat), 64'(N - 1));
    check({tag, "_e"}, 64'(o_e), ee);
    check({tag, "_match"}, 64'(o_match), 64'(ee == 64'(claim)));
    check({tag, "_psl"}, 64'(o_psl), pp);
  endtask

  initial begin
    logic [63:0] ee, pp;
    logic [N-1:0] rs;
    bit seen;

    // Reset state, before any clock edge.
    #2;
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_e", 64'(o_e), 64'd0);
    check("rst_match", 64'(o_match), 64'd0);
    check("rst_psl", 64'(o_psl), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_one(16'hFFFF, 20'd1240, "ffff");
    run_one(16'hAAAA, 20'd1000, "aaaa");
    run_one(16'h0001, 20'd820, "0001");

    // Barker-13 on the 13-bit instance.
    model(64'(13'b1111100110101), N2, ee, pp);
    b_seq   = 13'b1111100110101;
    b_e     = 20'd6;
    b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(posedge clk); #1;
      seen = b_ovalid;
    end
    check("barker_valid", 64'(seen), 64'd1);
    check("barker_e", 64'(b_oe), ee);
    check("barker_match", 64'(b_match), 64'd1);
    check("barker_psl", 64'(b_psl), pp);

    // Backpressure: result held while i_ready is low, competing input ignored.
    i_ready = 1'b0;
    i_seq   = 16'hFFFF;
    i_e     = 20'd1240;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(posedge clk); #1;
      seen = o_valid;
    end
    check("bp_valid0", 64'(seen), 64'd1);
    i_seq   = 16'h0001;
    i_e     = 20'd820;
    i_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(o_valid), 64'd1);
      check("bp_hold_e", 64'(o_e), 64'd1240);
      check("bp_hold_ready", 64'(o_ready), 64'd0);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_after_valid", 64'(o_valid), 64'd0);
    check("bp_after_ready", 64'(o_ready), 64'd1);
    @(posedge clk); #1;
    check("bp_accept", 64'(o_ready), 64'd0);
    i_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(posedge clk); #1;
      seen = o_valid;
    end
    check("bp_second_valid", 64'(seen), 64'd1);
    check("bp_second_e", 64'(o_e), 64'd820);
    check("bp_second_match", 64'(o_match), 64'd1);

    // Reset five cycles into CALC aborts without a result.
    for (int t = 0; t < 50 && !o_ready; t++) begin
      @(posedge clk); #1;
    end
    i_seq   = 16'h0001;
    i_e     = 20'd820;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", 64'(o_ready), 64'd1);
    check("abort_valid", 64'(o_valid), 64'd0);
    check("abort_e", 64'(o_e), 64'd0);
    check("abort_match", 64'(o_match), 64'd0);
    check("abort_psl", 64'(o_psl), 64'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_hold_valid", 64'(o_valid), 64'd0);
    end
    rst_n = 1'b1;
    run_one(16'hFFFF, 20'd1240, "post_rst");

    // Random sequences; claimed energy is either correct or random.
    for (int r = 0; r < 12; r++) begin
      rs = N'($urandom);
      model(64'(rs), N, ee, pp);
      if ($urandom_range(0, 1) == 1) run_one(rs, EW'(ee), "rand_ok");
      else run_one(rs, EW'($urandom_range(0, 2000)), "rand_any");
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/labs_energy_check.md
Name: labs_energy_check

Overview:
- Independent checker on the result side of the sequence search engine.
- Accepts a candidate binary sequence and its claimed energy over a valid/ready handshake.
- Recomputes the aperiodic autocorrelation energy serially, one lag per cycle.
- Returns the recomputed energy and a match flag, so search results can be validated before being reported.

Parameters:
- SEQ_WIDTH, 16, sequence length N in bits; legal range 3..64.
- E_WIDTH, 20, width of the claimed and computed energy; must hold sum over k=1..N-1 of (N-k)^2.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst_n, input, 1, asynchronous active-low reset; clears all state immediately.
- i_seq, input, SEQ_WIDTH, candidate sequence; element s_i = +1 if i_seq[i]=1, -1 if 0.
- i_e, input, E_WIDTH, claimed energy from the search engine.
- i_valid, input, 1, i_seq/i_e valid.
- o_ready, output, 1, checker can accept a new candidate.
- o_e, output, E_WIDTH, recomputed energy.
- o_match, output, 1, 1 when o_e == captured i_e.
- o_psl, output, SEQ_WIDTH bits, peak sidelobe max |C_k| (see Optional Feature).
- o_valid, output, 1, result valid.
- i_ready, input, 1, downstream accepts the result.

Behaviour:
- Reset values (rst_n low, asynchronous): state IDLE, o_ready=1, o_valid=0, o_e=0, o_match=0, o_psl=0, lag counter=1, all captured registers 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid & o_ready: capture i_seq and i_e, clear the accumulator, set k=1, go to CALC.
- CALC:
  - o_ready=0, o_valid=0.
  - Each cycle computes C_k = (N-k) - 2*popcount((seq ^ (seq >> k)) & ((1<<(N-k))-1)) as a signed value with |C_k| ≤ N-1.
  - Adds C_k^2 (unsigned) into the E_WIDTH accumulator; the accumulator wraps mod 2^E_WIDTH, with no saturation.
  - Increments k. When k == N-1 has been processed, go to DONE.
- DONE:
  - o_valid=1, with o_e, o_match and o_psl held stable.
  - o_ready=0, so an input presented in the same cycle as i_ready is not accepted.
  - On i_ready: o_valid drops the next cycle; go to IDLE.
- Latency: accept at edge T, o_valid high after edge T+N-1 (N-1 CALC cycles); throughput of one candidate per N+1 cycles minimum.
- i_valid while o_ready=0 is ignored. Upstream holds i_valid; no buffering.
- o_match is registered together with o_e and compares the full E_WIDTH bits.
- rst_n asserted mid-CALC or mid-DONE aborts immediately, with no result emitted. After release the block starts in IDLE with o_ready=1.
- Inputs are sampled only at acceptance; changes to i_seq/i_e during CALC have no effect.

Optional Feature:
- Macro LABS_PSL_EN.
- Defined: o_psl tracks max |C_k| over all lags, cleared at acceptance and valid with o_valid.
- Undefined: o_psl is tied to 0 and no PSL comparator is synthesized.
- o_e, o_match and timing are identical in both builds.

Test Plan:
- N=16, i_seq=16'hFFFF, i_e=1240 -> o_e=1240, o_match=1, o_psl=15 (PSL_EN); o_valid exactly 15 cycles after acceptance.
- N=16, i_seq=16'hAAAA, i_e=1000 -> o_e=1240, o_match=0, o_psl=15.
- N=16, i_seq=16'h0001, i_e=820 -> o_e=820, o_match=1, o_psl=13.
- SEQ_WIDTH=13, i_seq=13'b1111100110101 (Barker-13), i_e=6 -> o_e=6, o_match=1, o_psl=1.
- Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and o_e stable and o_ready=0 throughout; a second i_valid is not accepted until the cycle after the i_ready handshake.
- Drop rst_n 5 cycles into CALC -> outputs return to their reset values within the same cycle, with no o_valid pulse. After release, a new i_seq=16'hFFFF completes with o_e=1240.
